// File: rtl/reg_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reg_writeback (with package corePckg)
// Purpose  : Write-back arbiter for the register-file write port. Merges the
//            single-cycle ALU result path and the variable-latency load path.
//            Load results are buffered in a small FIFO. The ALU normally wins
//            the port, and a starvation counter forces a load drain after
//            STARVE_LIMIT consecutive ALU wins while loads are waiting.
//            A pending-write bitmap lets decode stall on queued destinations.
//
// Ports    : iClk       - clock
//            iRstN      - asynchronous active-low reset
//            iAluValid  - ALU result valid
//            iAluAddr   - ALU destination register
//            iAluData   - ALU result
//            oAluReady  - ALU result accepted when iAluValid && oAluReady
//            iLdValid   - load result valid
//            iLdAddr    - load destination register
//            iLdData    - load data
//            oLdReady   - load accepted when iLdValid && oLdReady
//            rdCntrl    - registered write control {en, addr}
//            rdData     - registered write data
//            oPending   - bit i set while a FIFO entry targets register i
//
// Options  : WB_LD_BYPASS_EN - when defined, a load arriving with the FIFO
//            empty and the ALU idle is written straight to the output
//            register (one cycle earlier) instead of being queued.
//
// Revision : 1.0 - initial release
// ============================================================================

package corePckg;
    localparam int cRegSelBitW = 5;
    localparam int cRegNum     = 32;
    localparam int cDataWidth  = 32;

    typedef struct packed {
        logic                   en;
        logic [cRegSelBitW-1:0] addr;
    } tRegControl;
endpackage

module reg_writeback
    import corePckg::*;
#(
    parameter int LD_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                   iClk,
    input  logic                   iRstN,

    input  logic                   iAluValid,
    input  logic [cRegSelBitW-1:0] iAluAddr,
    input  logic [cDataWidth-1:0]  iAluData,
    output logic                   oAluReady,

    input  logic                   iLdValid,
    input  logic [cRegSelBitW-1:0] iLdAddr,
    input  logic [cDataWidth-1:0]  iLdData,
    output logic                   oLdReady,

    output tRegControl             rdCntrl,
    output logic [cDataWidth-1:0]  rdData,
    output logic [cRegNum-1:0]     oPending
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int cIdxW = $clog2(LD_FIFO_DEPTH);
    localparam int cPtrW = cIdxW + 1;
    localparam int cCntW = $clog2(STARVE_LIMIT + 1);

    localparam logic [cCntW-1:0] cStarveLim = cCntW'(STARVE_LIMIT);

    // Write-port source chosen this cycle
    typedef enum logic [1:0] {
        SEL_IDLE     = 2'd0,
        SEL_ALU      = 2'd1,
        SEL_LD       = 2'd2,
        SEL_FORCE_LD = 2'd3
    } tSel_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [cRegSelBitW-1:0] fifoAddr_q [LD_FIFO_DEPTH];
    logic [cDataWidth-1:0]  fifoData_q [LD_FIFO_DEPTH];

    logic [cPtrW-1:0]      wrPtr_q,   wrPtr_d;
    logic [cPtrW-1:0]      rdPtr_q,   rdPtr_d;
    logic [cCntW-1:0]      starve_q,  starve_d;
    tRegControl            rdCntrl_q, rdCntrl_d;
    logic [cDataWidth-1:0] rdData_q,  rdData_d;

    // ------------------------------------------------------------------------
    // FIFO status, all from registered pointers
    // ------------------------------------------------------------------------
    logic                     fifoEmpty;
    logic                     fifoFull;
    logic [cPtrW-1:0]         fifoOcc;
    logic [cIdxW-1:0]         wrIdx;
    logic [cIdxW-1:0]         rdIdx;
    logic [cRegSelBitW-1:0]   headAddr;
    logic [cDataWidth-1:0]    headData;
    logic                     forceLd;

    assign wrIdx     = wrPtr_q[cIdxW-1:0];
    assign rdIdx     = rdPtr_q[cIdxW-1:0];
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    // Extra pointer bit disambiguates full from empty.
    assign fifoFull  = (wrPtr_q[cPtrW-1] != rdPtr_q[cPtrW-1]) && (wrIdx == rdIdx);
    assign fifoOcc   = wrPtr_q - rdPtr_q;
    assign headAddr  = fifoAddr_q[rdIdx];
    assign headData  = fifoData_q[rdIdx];

    // A full FIFO is drained even before the counter expires so that the load
    // path is never blocked by a continuous ALU stream for more than one slot.
    assign forceLd   = (!fifoEmpty && (starve_q == cStarveLim)) || fifoFull;

    assign oAluReady = !forceLd;
    assign oLdReady  = !fifoFull;

    // ------------------------------------------------------------------------
    // Arbitration and next-state
    // ------------------------------------------------------------------------
    tSel_e sel;
    logic  ldAccept;
    logic  enq;
    logic  deq;
`ifdef WB_LD_BYPASS_EN
    logic  ldBypass;
`endif

    always_comb begin
        sel = SEL_IDLE;
        if (forceLd) begin
            sel = SEL_FORCE_LD;
        end else if (iAluValid) begin
            sel = SEL_ALU;
        end else if (!fifoEmpty) begin
            sel = SEL_LD;
        end
    end

    always_comb begin
        ldAccept = iLdValid && !fifoFull;
`ifdef WB_LD_BYPASS_EN
        // Only an otherwise idle cycle may take the load directly; the FIFO is
        // necessarily empty then, so write order is preserved.
        ldBypass = ldAccept && (sel == SEL_IDLE);
        enq      = ldAccept && (iLdAddr != '0) && !ldBypass;
`else
        // Loads to x0 are consumed here and never reach the FIFO.
        enq      = ldAccept && (iLdAddr != '0);
`endif
    end

    always_comb begin
        rdCntrl_d    = rdCntrl_q;
        rdCntrl_d.en = 1'b0;
        rdData_d     = rdData_q;
        starve_d     = '0;
        deq          = 1'b0;

        unique case (sel)
            SEL_FORCE_LD, SEL_LD: begin
                deq            = 1'b1;
                rdCntrl_d.en   = 1'b1;
                rdCntrl_d.addr = headAddr;
                rdData_d       = headData;
            end
            SEL_ALU: begin
                if (iAluAddr != '0) begin
                    rdCntrl_d.en   = 1'b1;
                    rdCntrl_d.addr = iAluAddr;
                    rdData_d       = iAluData;
                end
                // Counter only tracks wins taken while a load is waiting; it
                // cannot pass the limit because the limit forces a drain.
                if (!fifoEmpty) begin
                    starve_d = starve_q + cCntW'(1);
                end
            end
            default: begin
`ifdef WB_LD_BYPASS_EN
                if (ldBypass && (iLdAddr != '0)) begin
                    rdCntrl_d.en   = 1'b1;
                    rdCntrl_d.addr = iLdAddr;
                    rdData_d       = iLdData;
                end
`endif
            end
        endcase

        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (enq) begin
            wrPtr_d = wrPtr_q + cPtrW'(1);
        end
        if (deq) begin
            rdPtr_d = rdPtr_q + cPtrW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            starve_q  <= '0;
            rdCntrl_q <= '0;
            rdData_q  <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            starve_q  <= starve_d;
            rdCntrl_q <= rdCntrl_d;
            rdData_q  <= rdData_d;
        end
    end

    // Storage needs no reset: slots are only observed while inside the
    // rd..wr window, and reset empties that window.
    always_ff @(posedge iClk) begin
        if (enq) begin
            fifoAddr_q[wrIdx] <= iLdAddr;
            fifoData_q[wrIdx] <= iLdData;
        end
    end

    assign rdCntrl = rdCntrl_q;
    assign rdData  = rdData_q;

    // ------------------------------------------------------------------------
    // Pending bitmap: a slot is live when its distance from the read index is
    // below the occupancy.
    // ------------------------------------------------------------------------
    logic [LD_FIFO_DEPTH-1:0] slotValid;

    for (genvar s = 0; s < LD_FIFO_DEPTH; s++) begin : g_slot
        logic [cIdxW-1:0] slotOff;
        assign slotOff      = cIdxW'(s) - rdIdx;
        assign slotValid[s] = ({1'b0, slotOff} < fifoOcc);
    end

    always_comb begin
        oPending = '0;
        for (int s = 0; s < LD_FIFO_DEPTH; s++) begin
            if (slotValid[s]) begin
                oPending[fifoAddr_q[s]] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback
// Purpose  : Self-checking bench for reg_writeback. Directed scenarios
//            (reset, ALU latency, starvation, FIFO full, wrap-around,
//            mid-operation reset) followed by random traffic, all compared
//            against a queue-based reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================

module tb_reg_writeback;
    import corePckg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic                   clk = 1'b0;
    logic                   rstN = 1'b0;
    logic                   aluV;
    logic [cRegSelBitW-1:0] aluA;
    logic [cDataWidth-1:0]  aluD;
    logic                   aluRdy;
    logic                   ldV;
    logic [cRegSelBitW-1:0] ldA;
    logic [cDataWidth-1:0]  ldD;
    logic                   ldRdy;
    tRegControl             rdC;
    logic [cDataWidth-1:0]  rdD;
    logic [cRegNum-1:0]     pend;

    always #5 clk = ~clk;

    reg_writeback #(
        .LD_FIFO_DEPTH (DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .iClk      (clk),
        .iRstN     (rstN),
        .iAluValid (aluV),
        .iAluAddr  (aluA),
        .iAluData  (aluD),
        .oAluReady (aluRdy),
        .iLdValid  (ldV),
        .iLdAddr   (ldA),
        .iLdData   (ldD),
        .oLdReady  (ldRdy),
        .rdCntrl   (rdC),
        .rdData    (rdD),
        .oPending  (pend)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of waiting loads, starvation count, last write.
    typedef struct packed {
        logic [cRegSelBitW-1:0] a;
        logic [cDataWidth-1:0]  d;
    } ent_t;

    ent_t                   q[$];
    int                     starve;
    logic                   expEn;
    logic [cRegSelBitW-1:0] expA;
    logic [cDataWidth-1:0]  expD;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        starve = 0;
        expEn  = 1'b0;
        expA   = '0;
        expD   = '0;
    endtask

    task automatic model_write(input logic [cRegSelBitW-1:0] a, input logic [cDataWidth-1:0] d);
        expEn = 1'b1;
        expA  = a;
        expD  = d;
    endtask

    // One clock: entered at posedge+1, drives inputs, checks the registered-
    // state outputs, advances the model, then checks the write port after
    // the edge. Leaves time at posedge+1.
    task automatic cycle(input logic aV, input logic [cRegSelBitW-1:0] aA,
                         input logic [cDataWidth-1:0] aD,
                         input logic lV, input logic [cRegSelBitW-1:0] lA,
                         input logic [cDataWidth-1:0] lD);
        int                 sz;
        bit                 full;
        bit                 frc;
        logic [cRegNum-1:0] pendExp;
        ent_t               e;

        aluV = aV; aluA = aA; aluD = aD;
        ldV  = lV; ldA  = lA; ldD  = lD;
        #1;
        sz   = q.size();
        full = (sz == DEPTH);
        frc  = (sz > 0 && starve == LIMIT) || full;
        pendExp = '0;
        foreach (q[i]) pendExp[q[i].a] = 1'b1;
        chk("alu_ready", aluRdy, !frc);
        chk("ld_ready",  ldRdy,  !full);
        chk("pending",   pend,   pendExp);

        expEn = 1'b0;
        if (frc) begin
            e = q.pop_front();
            model_write(e.a, e.d);
            starve = 0;
        end else if (aV) begin
            if (aA != 0) model_write(aA, aD);
            starve = (sz > 0) ? starve + 1 : 0;
        end else if (sz > 0) begin
            e = q.pop_front();
            model_write(e.a, e.d);
            starve = 0;
        end else begin
            starve = 0;
        end

        if (lV && !full && lA != 0) begin
            e.a = lA;
            e.d = lD;
`ifdef WB_LD_BYPASS_EN
            if (sz == 0 && !aV && !frc) model_write(lA, lD);
            else q.push_back(e);
`else
            q.push_back(e);
`endif
        end

        @(posedge clk);
        #1;
        chk("wr_en", rdC.en, expEn);
        if (expEn) begin
            chk("wr_addr", rdC.addr, expA);
            chk("wr_data", rdD, expD);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        aluV = 1'b0; aluA = '0; aluD = '0;
        ldV  = 1'b0; ldA  = '0; ldD  = '0;
        model_reset();

        // ---- Reset / idle ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en",      rdC.en,   1'b0);
        chk("rst_data",    rdD,      32'h0);
        chk("rst_pending", pend,     32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_alu_ready", aluRdy, 1'b1);
        chk("rel_ld_ready",  ldRdy,  1'b1);
        chk("rel_en",        rdC.en, 1'b0);
        chk("rel_data",      rdD,    32'h0);
        chk("rel_addr",      rdC.addr, 5'd0);

        // ---- ALU latency and x0 suppression ----
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        chk("alu_lat_en",   rdC.en,   1'b1);
        chk("alu_lat_addr", rdC.addr, 5'd5);
        chk("alu_lat_data", rdD,      32'hDEADBEEF);
        cycle(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, '0, '0);
        chk("alu_x0_en", rdC.en, 1'b0);
        idle(2);

        // ---- Starvation: one load waits behind a continuous ALU stream ----
        cycle(1'b1, 5'd3, 32'h0000_0003, 1'b1, 5'd7, 32'h7777_7777);
        for (int i = 0; i < 12; i++)
            cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, '0, '0);
        idle(2);

        // ---- FIFO full: four loads while ALU stays valid ----
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 5'd9, $urandom, 1'b1, 5'(i), 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 30; i++)
            cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, '0, '0);
        idle(3);

        // ---- Wrap-around: ten loads, ALU idle, occasional gaps ----
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 5'(i), 32'hA000_0000 + 32'(i));
            if (i % 3 == 0) idle(1);
        end
        idle(4);

        // ---- Mid-operation reset ----
        for (int i = 1; i <= 3; i++)
            cycle(1'b1, 5'd20, $urandom, 1'b1, 5'(10 + i), $urandom);
        cycle(1'b1, 5'd21, 32'h2121_2121, 1'b0, '0, '0);
        chk("pre_rst_en", rdC.en, 1'b1);
        aluV = 1'b0; ldV = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_en",      rdC.en, 1'b0);
        chk("mid_rst_pending", pend,   32'h0);
        chk("mid_rst_ld_rdy",  ldRdy,  1'b1);
        chk("mid_rst_alu_rdy", aluRdy, 1'b1);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_en", rdC.en, 1'b0);
        idle(6);

        // ---- Random traffic ----
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 31)), $urandom);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
